tick_timer: RTL

Programmable up-counting interval timer that issues a one-cycle `tick` each time its count reaches the programmed period, then wraps or holds. It is the counting-up counterpart of the team's load-and-count-down timer. Game logic uses it for periodic events such as sprite movement steps and animation frames, and in one-shot mode for fixed-length intervals such as power-pellet duration.

---
 rtl/tick_timer_if.sv | 26 ++
 rtl/tick_timer.sv | 68 ++++++
 2 files changed

// File: rtl/tick_timer_if.sv
// Control and status bundle for tick_timer; master drives controls, slave (the timer) drives status.
interface tick_timer_if #(
    parameter int PW     = 26,
    parameter int TICK_W = 8
);
    logic              enable;
    logic              clear;
    logic              oneshot;
    logic              load;
    logic [PW-1:0]     period;
    logic [PW-1:0]     count;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic              done;
    logic              period_err;

    modport master (
        output enable, clear, oneshot, load, period,
        input  count, tick, tick_count, done, period_err
    );

    modport slave (
        input  enable, clear, oneshot, load, period,
        output count, tick, tick_count, done, period_err
    );
endinterface

// File: rtl/tick_timer.sv
// Up-counting interval timer: one-cycle tick at count==period-1, then wrap or hold in DONE.
// Latency: all outputs registered (1 cycle); no backpressure, enable simply gates counting.
module tick_timer #(
    parameter int  MAX_PERIOD = 50000000,
    parameter int  TICK_W     = 8,
    localparam int PW         = $clog2(MAX_PERIOD + 1)
) (
    input logic         CLOCK_50,
    input logic         reset,
    tick_timer_if.slave bus
);
    typedef enum logic {RUN, DONE} state_t;

    state_t            state_q;
    logic [PW-1:0]     count_q;
    logic [PW-1:0]     period_q;
    logic              tick_q;
    logic [TICK_W-1:0] tick_count_q;
    logic              err_q;

    logic              load_ok_d;
    logic              terminal_d;

    assign load_ok_d  = bus.load && (bus.period != '0) && (bus.period <= PW'(MAX_PERIOD));
    assign terminal_d = (state_q == RUN) && bus.enable && (count_q == period_q - PW'(1));

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            count_q      <= '0;
            period_q     <= PW'(MAX_PERIOD);
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (bus.clear) begin
                state_q      <= RUN;
                count_q      <= '0;
                tick_count_q <= '0;
                err_q        <= 1'b0;
            end else begin
                if (bus.load && !load_ok_d) begin
                    err_q <= 1'b1;
                end
                // A valid load restarts the interval and swallows a coincident terminal tick.
                if (load_ok_d) begin
                    period_q <= bus.period;
                    count_q  <= '0;
                    state_q  <= RUN;
                end else if (terminal_d) begin
                    count_q      <= '0;
                    tick_q       <= 1'b1;
                    tick_count_q <= tick_count_q + TICK_W'(1);
                    state_q      <= bus.oneshot ? DONE : RUN;
                end else if (state_q == RUN && bus.enable) begin
                    count_q <= count_q + PW'(1);
                end
            end
        end
    end

    assign bus.count      = count_q;
    assign bus.tick       = tick_q;
    assign bus.tick_count = tick_count_q;
    assign bus.done       = (state_q == DONE);
    assign bus.period_err = err_q;
endmodule
